aes_kanal_hakem: RTL and testbench

Round-robin arbiter and result router that shares a single `aes_engine` instance between `KANAL_SAYISI` requesters. Each channel offers a key/block pair with a valid/ready handshake. The arbiter issues one pair at a time to the engine and records the owning channel in an in-order tag FIFO. When `c_gecerli` returns from the engine, the ciphertext is steered back to the owning channel. The block sits between the channel front-ends (FIFOs, DMA) and the `aes_engine` port set (`anahtar`, `blok`, `g_gecerli`, `hazir`, `sifre`, `c_gecerli`).

---
 rtl/aes_kanal_hakem.sv | 142 ++++++++++++++
 tb/tb_aes_kanal_hakem.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kanal_hakem.sv
// Round-robin arbiter sharing one AES engine between channels.
// In-order tag FIFO steers each ciphertext back to its requester.
module aes_kanal_hakem #(
  parameter int KANAL_SAYISI    = 4,
  parameter int ETIKET_DERINLIK = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [128*KANAL_SAYISI-1:0]       k_anahtar,
  input  logic [128*KANAL_SAYISI-1:0]       k_blok,
  input  logic [KANAL_SAYISI-1:0]           k_gecerli,
  output logic [KANAL_SAYISI-1:0]           k_hazir,
  output logic [127:0]                      k_sifre,
  output logic [KANAL_SAYISI-1:0]           k_c_gecerli,
  output logic [127:0]                      m_anahtar,
  output logic [127:0]                      m_blok,
  output logic                              m_g_gecerli,
  input  logic                              m_hazir,
  input  logic [127:0]                      m_sifre,
  input  logic                              m_c_gecerli,
  output logic [$clog2(ETIKET_DERINLIK):0]  bekleyen,
  output logic                              hata
);

  localparam int IW = $clog2(KANAL_SAYISI);
  localparam int AW = $clog2(ETIKET_DERINLIK);

  typedef enum logic {BOSTA, GONDER} durum_t;

  durum_t        r_durum;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_sahip;
  logic [IW-1:0] r_etiket [ETIKET_DERINLIK];
  logic [AW-1:0] r_yaz;
  logic [AW-1:0] r_oku;
  logic [AW:0]   r_bekleyen;
  logic [127:0]  r_m_anahtar;
  logic [127:0]  r_m_blok;
  logic          r_m_g_gecerli;
  logic [127:0]  r_k_sifre;
  logic [KANAL_SAYISI-1:0] r_k_c_gecerli;
  logic          r_hata;

  logic [IW-1:0] w_kazanan;
  logic          w_bulundu;
  logic          w_izin;
  logic          w_push;
  logic          w_pop;

  // first valid channel at or after ptr, wrapping
  always_comb begin
    logic [IW-1:0] idx;
    w_kazanan = '0;
    w_bulundu = 1'b0;
    idx       = '0;
    for (int i = 0; i < KANAL_SAYISI; i++) begin
      idx = IW'((int'(r_ptr) + i) % KANAL_SAYISI);
      if (!w_bulundu && k_gecerli[idx]) begin
        w_bulundu = 1'b1;
        w_kazanan = idx;
      end
    end
  end

  assign w_izin = rst && (r_durum == BOSTA) && w_bulundu &&
                  (r_bekleyen < (AW+1)'(ETIKET_DERINLIK));
  assign w_push = (r_durum == GONDER) && m_hazir;
  assign w_pop  = m_c_gecerli && (r_bekleyen != '0);

  always_comb begin
    k_hazir = '0;
    if (w_izin) k_hazir[w_kazanan] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_durum       <= BOSTA;
      r_ptr         <= '0;
      r_sahip       <= '0;
      r_yaz         <= '0;
      r_oku         <= '0;
      r_bekleyen    <= '0;
      r_m_anahtar   <= '0;
      r_m_blok      <= '0;
      r_m_g_gecerli <= 1'b0;
      r_k_sifre     <= '0;
      r_k_c_gecerli <= '0;
      r_hata        <= 1'b0;
      for (int i = 0; i < ETIKET_DERINLIK; i++) r_etiket[i] <= '0;
    end else begin
      unique case (r_durum)
        BOSTA: begin
          if (w_izin) begin
            r_sahip       <= w_kazanan;
            r_m_anahtar   <= k_anahtar[128*w_kazanan +: 128];
            r_m_blok      <= k_blok[128*w_kazanan +: 128];
            r_m_g_gecerli <= 1'b1;
            r_durum       <= GONDER;
          end
        end
        GONDER: begin
          if (m_hazir) begin
            r_ptr <= (r_sahip == IW'(KANAL_SAYISI-1)) ?
                     '0 : r_sahip + 1'b1;
            r_m_g_gecerli <= 1'b0;
            r_durum       <= BOSTA;
          end
        end
        default: r_durum <= BOSTA;
      endcase

      if (w_push) begin
        r_etiket[r_yaz] <= r_sahip;
        r_yaz           <= r_yaz + 1'b1;
      end

      r_k_c_gecerli <= '0;
      if (w_pop) begin
        r_oku                          <= r_oku + 1'b1;
        r_k_sifre                      <= m_sifre;
        r_k_c_gecerli[r_etiket[r_oku]] <= 1'b1;
      end

      if (m_c_gecerli && (r_bekleyen == '0)) r_hata <= 1'b1;

      unique case ({w_push, w_pop})
        2'b10:   r_bekleyen <= r_bekleyen + 1'b1;
        2'b01:   r_bekleyen <= r_bekleyen - 1'b1;
        default: r_bekleyen <= r_bekleyen;
      endcase
    end
  end

  assign m_anahtar   = r_m_anahtar;
  assign m_blok      = r_m_blok;
  assign m_g_gecerli = r_m_g_gecerli;
  assign k_sifre     = r_k_sifre;
  assign k_c_gecerli = r_k_c_gecerli;
  assign bekleyen    = r_bekleyen;
  assign hata        = r_hata;

endmodule

// File: tb/tb_aes_kanal_hakem.sv
// Directed bench for aes_kanal_hakem: arbitration, routing,
// full tag FIFO, engine stall, orphan result and async reset.
module tb_aes_kanal_hakem;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [128*N-1:0] k_anahtar;
  logic [128*N-1:0] k_blok;
  logic [N-1:0]   k_gecerli;
  logic [N-1:0]   k_hazir;
  logic [127:0]   k_sifre;
  logic [N-1:0]   k_c_gecerli;
  logic [127:0]   m_anahtar;
  logic [127:0]   m_blok;
  logic           m_g_gecerli;
  logic           m_hazir;
  logic [127:0]   m_sifre;
  logic           m_c_gecerli;
  logic [4:0]     bekleyen;
  logic           hata;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] KEY0 = 128'hC0DE0000_C0DE0000_C0DE0000_C0DE0000;
  localparam logic [127:0] BLK0 = 128'hB10C0000_B10C0000_B10C0000_B10C0000;
  localparam logic [127:0] KEY2 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
  localparam logic [127:0] BLK2 = 128'h000102030405060708090A0B0C0D0E0F;

  aes_kanal_hakem #(.KANAL_SAYISI(N), .ETIKET_DERINLIK(16)) dut (
    .clk(clk), .rst(rst),
    .k_anahtar(k_anahtar), .k_blok(k_blok),
    .k_gecerli(k_gecerli), .k_hazir(k_hazir),
    .k_sifre(k_sifre), .k_c_gecerli(k_c_gecerli),
    .m_anahtar(m_anahtar), .m_blok(m_blok),
    .m_g_gecerli(m_g_gecerli), .m_hazir(m_hazir),
    .m_sifre(m_sifre), .m_c_gecerli(m_c_gecerli),
    .bekleyen(bekleyen), .hata(hata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    k_gecerli   = '0;
    m_hazir     = 1'b0;
    m_sifre     = '0;
    m_c_gecerli = 1'b0;
    #12;
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    k_gecerli = 4'hF;
    #3;
    checks++;
    if (k_hazir !== 4'b0000) begin
      failures++;
      $display("FAIL rst_hazir got=%b exp=0000", k_hazir);
    end
    checks++;
    if (m_g_gecerli !== 1'b0 || m_anahtar !== '0 || m_blok !== '0) begin
      failures++;
      $display("FAIL rst_m got=%b/%h/%h exp=0/0/0",
               m_g_gecerli, m_anahtar, m_blok);
    end
    checks++;
    if (k_c_gecerli !== '0 || k_sifre !== '0 || bekleyen !== '0
        || hata !== 1'b0) begin
      failures++;
      $display("FAIL rst_k got=%b/%h/%0d/%b exp=0/0/0/0",
               k_c_gecerli, k_sifre, bekleyen, hata);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    m_hazir   = 1'b1;
    k_gecerli = 4'b0100;
    #1;
    checks++;
    if (k_hazir !== 4'b0100 || m_g_gecerli !== 1'b0) begin
      failures++;
      $display("FAIL single_grant got=%b/%b exp=0100/0",
               k_hazir, m_g_gecerli);
    end
    step();
    k_gecerli = '0;
    #1;
    checks++;
    if (m_g_gecerli !== 1'b1 || m_anahtar !== KEY2 || m_blok !== BLK2
        || k_hazir !== 4'b0000 || bekleyen !== 5'd0) begin
      failures++;
      $display("FAIL single_issue got=%b/%h/%h/%b/%0d",
               m_g_gecerli, m_anahtar, m_blok, k_hazir, bekleyen);
    end
    step();
    checks++;
    if (m_g_gecerli !== 1'b0 || bekleyen !== 5'd1) begin
      failures++;
      $display("FAIL single_push got=%b/%0d exp=0/1",
               m_g_gecerli, bekleyen);
    end
    m_c_gecerli = 1'b1;
    m_sifre     = 128'hABCD;
    #1;
    checks++;
    if (k_c_gecerli !== 4'b0000) begin
      failures++;
      $display("FAIL single_early got=%b exp=0000", k_c_gecerli);
    end
    step();
    m_c_gecerli = 1'b0;
    checks++;
    if (k_c_gecerli !== 4'b0100 || k_sifre !== 128'hABCD
        || bekleyen !== 5'd0) begin
      failures++;
      $display("FAIL single_result got=%b/%h/%0d exp=0100/abcd/0",
               k_c_gecerli, k_sifre, bekleyen);
    end
    step();
    checks++;
    if (k_c_gecerli !== 4'b0000) begin
      failures++;
      $display("FAIL single_pulse got=%b exp=0000", k_c_gecerli);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    m_hazir   = 1'b1;
    k_gecerli = 4'hF;
    for (int g = 0; g < 8; g++) begin
      exp = 4'(1 << (g % 4));
      #1;
      checks++;
      if (k_hazir !== exp) begin
        failures++;
        $display("FAIL rr_grant%0d got=%b exp=%b", g, k_hazir, exp);
      end
      step();
      checks++;
      if (k_hazir !== 4'b0000) begin
        failures++;
        $display("FAIL rr_gonder%0d got=%b exp=0000", g, k_hazir);
      end
      if (g == 0) begin
        checks++;
        if (m_anahtar !== KEY0 || m_blok !== BLK0) begin
          failures++;
          $display("FAIL rr_pair got=%h/%h", m_anahtar, m_blok);
        end
      end
      step();
    end
    k_gecerli = '0;
    checks++;
    if (bekleyen !== 5'd8) begin
      failures++;
      $display("FAIL rr_count got=%0d exp=8", bekleyen);
    end
    for (int i = 0; i < 8; i++) begin
      m_c_gecerli = 1'b1;
      m_sifre     = 128'(i + 100);
      step();
      exp = 4'(1 << (i % 4));
      checks++;
      if (k_c_gecerli !== exp || k_sifre !== 128'(i + 100)) begin
        failures++;
        $display("FAIL rr_route%0d got=%b/%0d exp=%b/%0d",
                 i, k_c_gecerli, k_sifre, exp, i + 100);
      end
    end
    m_c_gecerli = 1'b0;
    checks++;
    if (bekleyen !== 5'd0 || hata !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain got=%0d/%b exp=0/0", bekleyen, hata);
    end
  endtask

  task automatic test_out_of_order();
    logic [3:0] req [3];
    req[0] = 4'b1000;
    req[1] = 4'b0010;
    req[2] = 4'b0001;
    do_reset();
    m_hazir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k_gecerli = req[i];
      #1;
      checks++;
      if (k_hazir !== req[i]) begin
        failures++;
        $display("FAIL ooo_grant%0d got=%b exp=%b", i, k_hazir, req[i]);
      end
      step();
      k_gecerli = '0;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      m_c_gecerli = 1'b1;
      m_sifre     = 128'(i + 7);
      step();
      checks++;
      if (k_c_gecerli !== req[i]) begin
        failures++;
        $display("FAIL ooo_route%0d got=%b exp=%b",
                 i, k_c_gecerli, req[i]);
      end
    end
    m_c_gecerli = 1'b0;
  endtask

  task automatic test_full_fifo();
    logic [3:0] exp;
    do_reset();
    m_hazir   = 1'b1;
    k_gecerli = 4'hF;
    for (int g = 0; g < 16; g++) begin
      exp = 4'(1 << (g % 4));
      #1;
      checks++;
      if (k_hazir !== exp) begin
        failures++;
        $display("FAIL full_grant%0d got=%b exp=%b", g, k_hazir, exp);
      end
      step();
      step();
    end
    checks++;
    if (bekleyen !== 5'd16) begin
      failures++;
      $display("FAIL full_count got=%0d exp=16", bekleyen);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (k_hazir !== 4'b0000 || m_g_gecerli !== 1'b0) begin
        failures++;
        $display("FAIL full_block%0d got=%b/%b exp=0000/0",
                 i, k_hazir, m_g_gecerli);
      end
      step();
    end
    m_c_gecerli = 1'b1;
    m_sifre     = 128'h1;
    #1;
    checks++;
    if (k_hazir !== 4'b0000) begin
      failures++;
      $display("FAIL full_popcyc got=%b exp=0000", k_hazir);
    end
    step();
    m_c_gecerli = 1'b0;
    #1;
    checks++;
    if (bekleyen !== 5'd15 || k_c_gecerli !== 4'b0001
        || k_hazir !== 4'b0001) begin
      failures++;
      $display("FAIL full_unblock got=%0d/%b/%b exp=15/0001/0001",
               bekleyen, k_c_gecerli, k_hazir);
    end
    step();
    k_gecerli   = '0;
    m_c_gecerli = 1'b1;
    step();
    m_c_gecerli = 1'b0;
    checks++;
    if (bekleyen !== 5'd15 || k_c_gecerli !== 4'b0010) begin
      failures++;
      $display("FAIL full_pushpop got=%0d/%b exp=15/0010",
               bekleyen, k_c_gecerli);
    end
  endtask

  task automatic test_stall();
    do_reset();
    m_hazir   = 1'b0;
    k_gecerli = 4'b0001;
    #1;
    checks++;
    if (k_hazir !== 4'b0001) begin
      failures++;
      $display("FAIL stall_grant got=%b exp=0001", k_hazir);
    end
    step();
    k_gecerli = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (m_g_gecerli !== 1'b1 || m_blok !== BLK0 || m_anahtar !== KEY0
          || k_hazir !== 4'b0000 || bekleyen !== 5'd0) begin
        failures++;
        $display("FAIL stall_hold%0d got=%b/%h/%b/%0d",
                 i, m_g_gecerli, m_blok, k_hazir, bekleyen);
      end
      step();
    end
    m_hazir = 1'b1;
    #1;
    checks++;
    if (m_g_gecerli !== 1'b1) begin
      failures++;
      $display("FAIL stall_last got=%b exp=1", m_g_gecerli);
    end
    step();
    checks++;
    if (bekleyen !== 5'd1 || m_g_gecerli !== 1'b0
        || k_hazir !== 4'b0010) begin
      failures++;
      $display("FAIL stall_push got=%0d/%b/%b exp=1/0/0010",
               bekleyen, m_g_gecerli, k_hazir);
    end
    k_gecerli = '0;
    step();
  endtask

  task automatic test_orphan_reset();
    do_reset();
    m_c_gecerli = 1'b1;
    m_sifre     = 128'h55;
    step();
    m_c_gecerli = 1'b0;
    checks++;
    if (hata !== 1'b1 || k_c_gecerli !== 4'b0000 || bekleyen !== 5'd0) begin
      failures++;
      $display("FAIL orphan got=%b/%b/%0d exp=1/0000/0",
               hata, k_c_gecerli, bekleyen);
    end
    m_hazir   = 1'b0;
    k_gecerli = 4'b0100;
    step();
    checks++;
    if (hata !== 1'b1 || m_g_gecerli !== 1'b1 || m_anahtar !== KEY2) begin
      failures++;
      $display("FAIL orphan_sticky got=%b/%b/%h exp=1/1/key2",
               hata, m_g_gecerli, m_anahtar);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (m_g_gecerli !== 1'b0 || m_anahtar !== '0 || m_blok !== '0
        || hata !== 1'b0 || k_hazir !== 4'b0000 || bekleyen !== 5'd0
        || k_c_gecerli !== 4'b0000 || k_sifre !== '0) begin
      failures++;
      $display("FAIL async_rst got=%b/%h/%b/%b/%0d",
               m_g_gecerli, m_anahtar, hata, k_hazir, bekleyen);
    end
    k_gecerli = '0;
    rst       = 1'b1;
    step();
    m_c_gecerli = 1'b1;
    step();
    m_c_gecerli = 1'b0;
    checks++;
    if (hata !== 1'b1 || k_c_gecerli !== 4'b0000) begin
      failures++;
      $display("FAIL post_rst_orphan got=%b/%b exp=1/0000",
               hata, k_c_gecerli);
    end
  endtask

  initial begin
    k_gecerli   = '0;
    m_hazir     = 1'b0;
    m_sifre     = '0;
    m_c_gecerli = 1'b0;
    for (int i = 0; i < N; i++) begin
      k_anahtar[128*i +: 128] = {4{32'hC0DE0000 | 32'(i)}};
      k_blok[128*i +: 128]    = {4{32'hB10C0000 | 32'(i)}};
    end
    k_anahtar[256 +: 128] = KEY2;
    k_blok[256 +: 128]    = BLK2;
    test_reset();
    test_single();
    test_round_robin();
    test_out_of_order();
    test_full_fifo();
    test_stall();
    test_orphan_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
